// File: rtl/fifo_pkg.sv
// Shared types for the synchronous FIFO: the per-cycle operation decoded from
// the accepted write/read pair.
package fifo_pkg;

  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data, occupancy count and
// sticky overflow/underflow flags.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic     wr_acc;
  logic     rd_acc;
  fifo_op_e op;

  // Flags derive only from registered state; accept decisions see pre-edge values.
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q  | (wr_en && full);
    underflow_d = underflow_q | (rd_en && empty);

    // DEPTH is a power of two, so pointer wrap is plain AW-bit rollover.
    unique case (op)
      OpIdle: ;
      OpWrite: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(1);
      end
      OpRead: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q];
        count_d  = count_q - (AW+1)'(1);
      end
      OpBoth: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes are still blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo (WIDTH=8, DEPTH=8): queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         full, empty, overflow, underflow;
  logic [3:0]   count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;

  fifo #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .din      (din),
    .full     (full),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decisions from the pre-edge occupancy, read before write.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      int n;
      n = mq.size();
      if (rd_en && n != 0) m_dout = mq.pop_front();
      if (rd_en && n == 0) m_udf = 1'b1;
      if (wr_en && n != D) mq.push_back(din);
      if (wr_en && n == D) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_full", 32'(full), 32'(mq.size() == D));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_dout", 32'(dout), 32'(m_dout));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_udf));
    end
  end

  // Present inputs for one edge; returns 1ns after that edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input bit w, input logic [W-1:0] d);
    rst   = 1'b1;
    wr_en = w;
    din   = d;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(1'b0, '0);
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(dout), 0);

    // Fill and drain
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, W'(i));
      chk("fill_full", 32'(full), (i == 8) ? 1 : 0);
    end
    chk("fill_count", 32'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_data", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf", 32'(overflow), 0);
    chk("drain_udf", 32'(underflow), 0);

    // Overflow
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(8'h10 + i));
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("ovf_drain", 32'(dout), 32'(8'h10 + i));
    end

    // Underflow
    step(1'b0, 1'b1, '0);
    chk("udf_dout", 32'(dout), 32'h17);
    chk("udf_count", 32'(count), 0);
    chk("udf_flag", 32'(underflow), 1);

    // Simultaneous with count=3, across pointer wrap
    do_reset(1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(8'h21 + i));
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, W'(8'h30 + k));
      chk("both_count", 32'(count), 3);
      chk("both_dout", 32'(dout), (k < 3) ? 32'(8'h21 + k) : 32'(8'h30 + k - 3));
    end

    // Simultaneous on full, then on empty
    do_reset(1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(8'h40 + i));
    step(1'b1, 1'b1, 8'h55);
    chk("bfull_count", 32'(count), 7);
    chk("bfull_ovf", 32'(overflow), 1);
    chk("bfull_dout", 32'(dout), 32'h40);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("bfull_drain", 32'(dout), 32'(8'h40 + i));
    end
    step(1'b1, 1'b1, 8'h66);
    chk("bempty_count", 32'(count), 1);
    chk("bempty_udf", 32'(underflow), 1);
    chk("bempty_dout", 32'(dout), 32'h47);
    step(1'b0, 1'b1, '0);
    chk("bempty_read", 32'(dout), 32'h66);

    // Reset mid-stream with wr_en high
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(8'h70 + i));
    do_reset(1'b1, 8'h77);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_udf", 32'(underflow), 0);
    step(1'b1, 1'b0, 8'h99);
    step(1'b0, 1'b1, '0);
    chk("mrst_data", 32'(dout), 32'h99);

    // Random traffic, occasional reset
    for (int k = 0; k < 3000; k++) begin
      int bias;
      bias  = (k / 500) % 3;
      rst   = ($urandom_range(0, 299) == 0);
      wr_en = ($urandom_range(0, 9) < ((bias == 0) ? 7 : (bias == 1) ? 3 : 5));
      rd_en = ($urandom_range(0, 9) < ((bias == 0) ? 3 : (bias == 1) ? 7 : 5));
      din   = W'($urandom);
      @(posedge clk);
      #1;
    end
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of entries; power of two, >= 2.
REQ-003 Derived constant AW = $clog2(DEPTH), pointer/index width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write request from the producer (e.g. UART receiver).
REQ-007 din  input  WIDTH  write data, sampled with wr_en.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 rd_en  input  1  read request from the consumer (e.g. memory controller).
REQ-010 dout  output  WIDTH  read data, registered.
REQ-011 empty  output  1  high when count == 0.
REQ-012 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag for a write attempted while full.
REQ-014 underflow  output  1  sticky flag for a read attempted while empty.

Function
REQ-015 Write accepted iff wr_en && !full; din is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-016 Read accepted iff rd_en && !empty; the entry at rd_ptr goes to dout on the same edge, and rd_ptr increments modulo DEPTH.
REQ-017 Read latency is one cycle: dout is valid the cycle after rd_en is sampled high with empty low.
REQ-018 dout holds its last value when no read is accepted.
REQ-019 full, empty and count are combinational from registered state; no bypass path exists.
REQ-020 Accept decisions use the flag values before the edge.
REQ-021 Simultaneous wr_en and rd_en, 0 < count < DEPTH: both are accepted and count is unchanged.
REQ-022 Simultaneous wr_en and rd_en, count == DEPTH: only the read is accepted; count becomes DEPTH-1 and overflow is set.
REQ-023 Simultaneous wr_en and rd_en, count == 0: only the write is accepted; count becomes 1, underflow is set, and dout is unchanged.
REQ-024 A write-only accept increments count by 1.
REQ-025 A read-only accept decrements count by 1.
REQ-026 count never exceeds DEPTH and never wraps below 0.
REQ-027 Refused requests do not alter pointers, count or storage.
REQ-028 overflow and underflow, once set, stay high until reset.
REQ-029 Pointer wrap from DEPTH-1 to 0 is seamless, with no lost or duplicated entry.

Reset
REQ-030 On rst: wr_ptr = 0, rd_ptr = 0, count = 0, dout = 0, overflow = 0, underflow = 0.
REQ-031 Flags after reset: empty = 1 and full = 0 in the cycle after rst is sampled high.
REQ-032 Reset in the middle of traffic discards all contents; wr_en and rd_en are ignored during the rst cycle.
REQ-033 Storage array contents are not reset.

Structure
REQ-034 No shared package is required; WIDTH and DEPTH are the only module parameters, and AW is local.
REQ-035 Single module with no sub-module; storage is an inferred reg array of DEPTH x WIDTH.

Verification
REQ-036 Bench uses WIDTH=8, DEPTH=8; all checks happen after rst.
REQ-037 Fill and drain: write 0x01..0x08 back-to-back, then read 8 -> full rises after the 8th write; reads return 0x01..0x08 in order, one cycle after each rd_en; empty after the last read; flags stay 0.
REQ-038 Overflow: on a full FIFO, pulse wr_en with din=0xAA -> count stays 8 and overflow=1; a subsequent drain shows no 0xAA.
REQ-039 Underflow: on an empty FIFO, pulse rd_en -> dout unchanged, count 0, underflow=1.
REQ-040 Simultaneous access: with count=3, hold wr_en and rd_en for 10 cycles -> count stays 3 and the output order is preserved across pointer wrap.
REQ-041 Simultaneous access on full and on empty -> behaviour per REQ-022 and REQ-023 exactly.
REQ-042 Reset mid-stream: write 5 words, assert rst with wr_en=1 -> count 0, empty 1, flags 0; the next write then read returns the new data.
